// File: rtl/aes_mix_columns_iter_if.sv
// Handshake and data bundle for aes_mix_columns_iter.
// The producer/consumer side uses master; the block itself uses slave.
interface aes_mix_columns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         inv_mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  modport master (
    output in_valid, state_in, inv_mode, out_ready,
    input  in_ready, out_valid, state_out, busy
  );

  modport slave (
    input  in_valid, state_in, inv_mode, out_ready,
    output in_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/aes_mix_columns_iter.sv
// Iterative AES MixColumns over a 128-bit state, COLS_PER_CYCLE columns per RUN cycle.
// Define AES_MIXCOL_INV_EN to add the InvMixColumns datapath selected by inv_mode.
module aes_mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_mix_columns_iter_if.slave bus
);

  if (!((COLS_PER_CYCLE == 1) || (COLS_PER_CYCLE == 2) || (COLS_PER_CYCLE == 4))) begin : g_bad_cols
    $error("aes_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    s0 = c[31:24];
    s1 = c[23:16];
    s2 = c[15:8];
    s3 = c[7:0];
    return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
            xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
  endfunction

`ifdef AES_MIXCOL_INV_EN
  // Multiples 9/b/d/e are built from the x2/x4/x8 chain of each byte.
  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] s[4];
    logic [7:0] m2, m4, m8;
    logic [7:0] m9[4], mb[4], md[4], me[4];
    logic [31:0] y;
    y = 32'h0;
    for (int i = 0; i < 4; i++) begin
      s[i]  = c[31 - 8*i -: 8];
      m2    = xtime(s[i]);
      m4    = xtime(m2);
      m8    = xtime(m4);
      m9[i] = m8 ^ s[i];
      mb[i] = m8 ^ m2 ^ s[i];
      md[i] = m8 ^ m4 ^ s[i];
      me[i] = m8 ^ m4 ^ m2;
    end
    for (int r = 0; r < 4; r++) begin
      y[31 - 8*r -: 8] = me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4];
    end
    return y;
  endfunction
`endif

  state_e       fsm_q, fsm_d;
  logic [127:0] data_q, data_d;
  logic [1:0]   idx_q, idx_d;
  logic [1:0]   col_s;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;
`ifdef AES_MIXCOL_INV_EN
  logic         inv_q, inv_d;
`endif

  // Next-state, in-place column update and output flag decode.
  always_comb begin
    fsm_d  = fsm_q;
    data_d = data_q;
    idx_d  = idx_q;
    col_s  = 2'd0;
`ifdef AES_MIXCOL_INV_EN
    inv_d  = inv_q;
`endif
    case (fsm_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          fsm_d  = ST_RUN;
          data_d = bus.state_in;
          idx_d  = 2'd0;
`ifdef AES_MIXCOL_INV_EN
          inv_d  = bus.inv_mode;
`endif
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // idx is always a multiple of COLS_PER_CYCLE, so idx+k never wraps.
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          col_s = idx_q + 2'(k);
`ifdef AES_MIXCOL_INV_EN
          data_d[127 - 32*col_s -: 32] = inv_q ? mix_inv(data_q[127 - 32*col_s -: 32])
                                               : mix_fwd(data_q[127 - 32*col_s -: 32]);
`else
          data_d[127 - 32*col_s -: 32] = mix_fwd(data_q[127 - 32*col_s -: 32]);
`endif
        end
        idx_d = idx_q + STEP;
        if ((int'(idx_q) + COLS_PER_CYCLE) >= 4) begin
          fsm_d = ST_DONE;
        end else begin
          fsm_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          fsm_d = ST_IDLE;
        end else begin
          fsm_d = ST_DONE;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (fsm_d == ST_IDLE);
    out_valid_d = (fsm_d == ST_DONE);
    busy_d      = (fsm_d != ST_IDLE);
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= ST_IDLE;
      data_q      <= 128'h0;
      idx_q       <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef AES_MIXCOL_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef AES_MIXCOL_INV_EN
      inv_q       <= inv_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.state_out = data_q;

endmodule
